// File: rtl/tl_tx_arbiter_pkg.sv
// Shared types and helpers for the transaction-layer Tx egress arbiter.
// Header layout follows the PCIe 4DW memory request, DW0 in the low 32 bits.
package tl_tx_arbiter_pkg;

  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

  localparam int FC_PH_W  = 8;
  localparam int FC_PD_W  = 12;
  localparam int FC_NPH_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    P_HDR,
    P_DATA,
    NP_HDR
  } tx_arb_state_t;

  typedef struct packed {
    logic [31:0] addr_l;
    logic [31:0] addr_h;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic        t9;
    logic [2:0]  tc;
    logic        t8;
    logic        attr2;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [1:0]  length_h;
    logic [7:0]  length_l;
  } tlp_memory_req_hdr_t;

  // A length field of zero encodes the maximum payload of 1024 DW.
  function automatic logic [10:0] len_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  function automatic logic [8:0] pd_need(input logic [9:0] len);
    return 9'((len_dw(len) + 11'd3) >> 2);
  endfunction

  function automatic logic [7:0] data_beats(input logic [9:0] len);
    return 8'((len_dw(len) + 11'd7) >> 3);
  endfunction

endpackage

// File: rtl/tl_tx_arbiter_fc_credit_cnt.sv
// One flow-control credit class: consumed counter plus the availability check
// against the DLL limit, modulo 2^N.
module tl_fc_credit_cnt #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] limit,
  input  logic [N-1:0] need,
  input  logic         consume,
  input  logic [N-1:0] amount,
  output logic         eligible
);

  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] cons_q;
  logic [N-1:0] avail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cons_q <= '0;
    end else if (consume) begin
      cons_q <= cons_q + amount;
    end
  end

  // Anything above half-range means the limit is behind us, not ahead.
  assign avail    = limit - cons_q;
  assign eligible = (avail != '0) && (need <= avail) && (avail <= HALF);

endmodule

// File: rtl/tl_tx_arbiter.sv
// Tx egress arbiter: drains P header/data and NP header FIFOs into a single
// 256-bit TLP stream, gated on PH/PD/NPH credits with NP never passing P.
module tl_tx_arbiter
  import tl_tx_arbiter_pkg::*;
#(
  parameter int TX_DEPTH_LG2 = 3,
  parameter int PH_W         = FC_PH_W,
  parameter int PD_W         = FC_PD_W,
  parameter int NPH_W        = FC_NPH_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_hdr_empty_i,
  input  logic [127:0]            p_hdr_rdata_i,
  output logic                    p_hdr_rden_o,
  input  logic                    p_data_empty_i,
  input  logic [255:0]            p_data_rdata_i,
  output logic                    p_data_rden_o,
  input  logic [TX_DEPTH_LG2-1:0] p_payload_cnt_i,
  output logic                    p_sent_o,
  input  logic                    np_hdr_empty_i,
  input  logic [127:0]            np_hdr_rdata_i,
  output logic                    np_hdr_rden_o,
  input  logic [PH_W-1:0]         fc_ph_limit_i,
  input  logic [PD_W-1:0]         fc_pd_limit_i,
  input  logic [NPH_W-1:0]        fc_nph_limit_i,
  output logic                    tlp_valid_o,
  output logic [255:0]            tlp_data_o,
  output logic                    tlp_sop_o,
  output logic                    tlp_eop_o,
  input  logic                    tlp_ready_i
);

  localparam logic [PH_W-1:0]  PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};
  localparam logic [NPH_W-1:0] NPH_ONE = {{(NPH_W-1){1'b0}}, 1'b1};

  tx_arb_state_t       state_q, state_d;
  logic [7:0]          beat_q, beat_d;
  tlp_memory_req_hdr_t p_hdr;
  logic [9:0]          p_len;
  logic [7:0]          p_beats;
  logic [PD_W-1:0]     pd_need_w;
  logic                ph_ok, pd_ok, nph_ok;
  logic                p_elig, np_elig;
  logic                p_consume, np_consume;

  assign p_hdr     = tlp_memory_req_hdr_t'(p_hdr_rdata_i);
  assign p_len     = {p_hdr.length_h, p_hdr.length_l};
  assign pd_need_w = {{(PD_W-9){1'b0}}, pd_need(p_len)};
  assign p_beats   = data_beats(p_len);

  tl_fc_credit_cnt #(.N(PH_W)) u_ph_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .limit    (fc_ph_limit_i),
    .need     (PH_ONE),
    .consume  (p_consume),
    .amount   (PH_ONE),
    .eligible (ph_ok)
  );

  tl_fc_credit_cnt #(.N(PD_W)) u_pd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .limit    (fc_pd_limit_i),
    .need     (pd_need_w),
    .consume  (p_consume),
    .amount   (pd_need_w),
    .eligible (pd_ok)
  );

  tl_fc_credit_cnt #(.N(NPH_W)) u_nph_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .limit    (fc_nph_limit_i),
    .need     (NPH_ONE),
    .consume  (np_consume),
    .amount   (NPH_ONE),
    .eligible (nph_ok)
  );

  // A pending P header blocks NP even when that P is itself credit-starved.
  assign p_elig  = !p_hdr_empty_i && (p_payload_cnt_i != '0) && ph_ok && pd_ok;
  assign np_elig = !np_hdr_empty_i && p_hdr_empty_i && nph_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    p_consume     = 1'b0;
    np_consume    = 1'b0;
    p_hdr_rden_o  = 1'b0;
    p_data_rden_o = 1'b0;
    np_hdr_rden_o = 1'b0;
    p_sent_o      = 1'b0;
    tlp_valid_o   = 1'b0;
    tlp_data_o    = '0;
    tlp_sop_o     = 1'b0;
    tlp_eop_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_elig) begin
          state_d = P_HDR;
        end else if (np_elig) begin
          state_d = NP_HDR;
        end
      end
      P_HDR: begin
        tlp_valid_o = 1'b1;
        tlp_sop_o   = 1'b1;
        tlp_data_o  = {128'b0, p_hdr};
        if (tlp_ready_i) begin
          p_hdr_rden_o = 1'b1;
          p_consume    = 1'b1;
          beat_d       = p_beats - 8'd1;
          state_d      = P_DATA;
        end
      end
      P_DATA: begin
        tlp_valid_o = !p_data_empty_i;
        tlp_data_o  = p_data_rdata_i;
        tlp_eop_o   = (beat_q == 8'd0);
        if (!p_data_empty_i && tlp_ready_i) begin
          p_data_rden_o = 1'b1;
          if (beat_q == 8'd0) begin
            p_sent_o = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      NP_HDR: begin
        tlp_valid_o = 1'b1;
        tlp_sop_o   = 1'b1;
        tlp_eop_o   = 1'b1;
        tlp_data_o  = {128'b0, np_hdr_rdata_i};
        if (tlp_ready_i) begin
          np_hdr_rden_o = 1'b1;
          np_consume    = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Directed bench for tl_tx_arbiter with small show-ahead FIFO models upstream.
module tb_tl_tx_arbiter;
  import tl_tx_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         p_hdr_empty_i;
  logic [127:0] p_hdr_rdata_i;
  logic         p_hdr_rden_o;
  logic         p_data_empty_i;
  logic [255:0] p_data_rdata_i;
  logic         p_data_rden_o;
  logic [2:0]   p_payload_cnt_i;
  logic         p_sent_o;
  logic         np_hdr_empty_i;
  logic [127:0] np_hdr_rdata_i;
  logic         np_hdr_rden_o;
  logic [7:0]   fc_ph_limit_i = '0;
  logic [11:0]  fc_pd_limit_i = '0;
  logic [7:0]   fc_nph_limit_i = '0;
  logic         tlp_valid_o;
  logic [255:0] tlp_data_o;
  logic         tlp_sop_o;
  logic         tlp_eop_o;
  logic         tlp_ready_i = 1'b1;

  int total = 0;
  int bad = 0;
  int ph_m = 0, pd_m = 0, nph_m = 0;

  tl_tx_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .p_hdr_empty_i   (p_hdr_empty_i),
    .p_hdr_rdata_i   (p_hdr_rdata_i),
    .p_hdr_rden_o    (p_hdr_rden_o),
    .p_data_empty_i  (p_data_empty_i),
    .p_data_rdata_i  (p_data_rdata_i),
    .p_data_rden_o   (p_data_rden_o),
    .p_payload_cnt_i (p_payload_cnt_i),
    .p_sent_o        (p_sent_o),
    .np_hdr_empty_i  (np_hdr_empty_i),
    .np_hdr_rdata_i  (np_hdr_rdata_i),
    .np_hdr_rden_o   (np_hdr_rden_o),
    .fc_ph_limit_i   (fc_ph_limit_i),
    .fc_pd_limit_i   (fc_pd_limit_i),
    .fc_nph_limit_i  (fc_nph_limit_i),
    .tlp_valid_o     (tlp_valid_o),
    .tlp_data_o      (tlp_data_o),
    .tlp_sop_o       (tlp_sop_o),
    .tlp_eop_o       (tlp_eop_o),
    .tlp_ready_i     (tlp_ready_i)
  );

  always #5 clk = ~clk;

  // Upstream FIFO models; they share rst_n with the DUT.
  logic [127:0] ph_mem [8];
  logic [255:0] pd_mem [8];
  logic [127:0] np_mem [8];
  logic [3:0]   ph_wr = '0, ph_rd = '0, pd_wr = '0, pd_rd = '0, np_wr = '0, np_rd = '0;
  int           pl_pushed = 0, pl_sent = 0;

  assign p_hdr_empty_i   = (ph_wr == ph_rd);
  assign p_hdr_rdata_i   = ph_mem[ph_rd[2:0]];
  assign p_data_empty_i  = (pd_wr == pd_rd);
  assign p_data_rdata_i  = pd_mem[pd_rd[2:0]];
  assign np_hdr_empty_i  = (np_wr == np_rd);
  assign np_hdr_rdata_i  = np_mem[np_rd[2:0]];
  assign p_payload_cnt_i = 3'(pl_pushed - pl_sent);

  always @(posedge clk) begin
    if (!rst_n) begin
      ph_rd   <= ph_wr;
      pd_rd   <= pd_wr;
      np_rd   <= np_wr;
      pl_sent <= pl_pushed;
    end else begin
      if (p_hdr_rden_o)  ph_rd <= ph_rd + 4'd1;
      if (p_data_rden_o) pd_rd <= pd_rd + 4'd1;
      if (np_hdr_rden_o) np_rd <= np_rd + 4'd1;
      if (p_sent_o)      pl_sent <= pl_sent + 1;
    end
  end

  wire [2:0] ctl  = {tlp_valid_o, tlp_sop_o, tlp_eop_o};
  wire [3:0] pops = {p_hdr_rden_o, p_data_rden_o, np_hdr_rden_o, p_sent_o};

  function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [9:0] len,
                                          input logic [31:0] addr);
    logic [127:0] h;
    h = '0;
    h[127:96] = addr;
    h[31:29]  = fmt;
    h[9:0]    = len;
    return h;
  endfunction

  function automatic logic [255:0] dword(input int base, input int i);
    return {8{base + i}};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_p(input logic [127:0] hdr, input int beats, input int base);
    ph_mem[ph_wr[2:0]] = hdr;
    ph_wr = ph_wr + 4'd1;
    for (int i = 0; i < beats; i++) begin
      pd_mem[pd_wr[2:0]] = dword(base, i);
      pd_wr = pd_wr + 4'd1;
    end
    pl_pushed = pl_pushed + 1;
  endtask

  task automatic push_np(input logic [127:0] hdr);
    np_mem[np_wr[2:0]] = hdr;
    np_wr = np_wr + 4'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, IDLE); end
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b exp=000", ctl); end
    total++; if (pops !== 4'b0000) begin bad++; $display("FAIL rst_pops got=%b exp=0000", pops); end
    total++; if (tlp_data_o !== 256'b0) begin bad++; $display("FAIL rst_data got=%h exp=0", tlp_data_o); end
    total++;
    if ({dut.u_ph_cnt.cons_q, dut.u_pd_cnt.cons_q, dut.u_nph_cnt.cons_q} !== 28'b0) begin
      bad++; $display("FAIL rst_cons got=%h exp=0",
                      {dut.u_ph_cnt.cons_q, dut.u_pd_cnt.cons_q, dut.u_nph_cnt.cons_q});
    end
    total++; if (dut.beat_q !== 8'd0) begin bad++; $display("FAIL rst_beat got=%0d exp=0", dut.beat_q); end
    rst_n = 1'b1;
    tick();
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL rst_idle_ctl got=%b exp=000", ctl); end
  endtask

  task automatic test_single_p();
    logic [127:0] h;
    fc_ph_limit_i = 8'd8; fc_pd_limit_i = 12'd64; fc_nph_limit_i = 8'd8;
    h = mk_hdr(FMT_4DW_DATA, 10'd16, 32'h1000_0000);
    push_p(h, 2, 32'h10);
    tick();
    total++; if (ctl !== 3'b110) begin bad++; $display("FAIL p1_hdr_ctl got=%b exp=110", ctl); end
    total++; if (tlp_data_o !== {128'b0, h}) begin bad++; $display("FAIL p1_hdr_data got=%h exp=%h", tlp_data_o, {128'b0, h}); end
    total++; if (pops !== 4'b1000) begin bad++; $display("FAIL p1_hdr_pops got=%b exp=1000", pops); end
    tick();
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL p1_d0_ctl got=%b exp=100", ctl); end
    total++; if (tlp_data_o !== dword(32'h10, 0)) begin bad++; $display("FAIL p1_d0_data got=%h exp=%h", tlp_data_o, dword(32'h10, 0)); end
    total++; if (pops !== 4'b0100) begin bad++; $display("FAIL p1_d0_pops got=%b exp=0100", pops); end
    tick();
    total++; if (ctl !== 3'b101) begin bad++; $display("FAIL p1_d1_ctl got=%b exp=101", ctl); end
    total++; if (tlp_data_o !== dword(32'h10, 1)) begin bad++; $display("FAIL p1_d1_data got=%h exp=%h", tlp_data_o, dword(32'h10, 1)); end
    total++; if (pops !== 4'b0101) begin bad++; $display("FAIL p1_d1_pops got=%b exp=0101", pops); end
    tick();
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL p1_idle_ctl got=%b exp=000", ctl); end
    ph_m = 1; pd_m = 4;
    total++; if (dut.u_ph_cnt.cons_q !== 8'(ph_m)) begin bad++; $display("FAIL p1_ph_cons got=%0d exp=%0d", dut.u_ph_cnt.cons_q, ph_m); end
    total++; if (dut.u_pd_cnt.cons_q !== 12'(pd_m)) begin bad++; $display("FAIL p1_pd_cons got=%0d exp=%0d", dut.u_pd_cnt.cons_q, pd_m); end
  endtask

  task automatic test_p_before_np();
    logic [127:0] hp, hn;
    hp = mk_hdr(FMT_4DW_DATA, 10'd8, 32'h2000_0000);
    hn = mk_hdr(FMT_4DW_NODATA, 10'd1, 32'h3000_0000);
    push_np(hn);
    push_p(hp, 1, 32'h20);
    tick();
    total++; if (ctl !== 3'b110 || tlp_data_o !== {128'b0, hp}) begin bad++; $display("FAIL ord_p_hdr got=%b/%h exp=110/%h", ctl, tlp_data_o[127:0], hp); end
    tick();
    total++; if (ctl !== 3'b101 || pops !== 4'b0101) begin bad++; $display("FAIL ord_p_data got=%b/%b exp=101/0101", ctl, pops); end
    tick();
    total++; if (ctl !== 3'b000 || pops !== 4'b0000) begin bad++; $display("FAIL ord_bubble got=%b/%b exp=000/0000", ctl, pops); end
    tick();
    total++; if (ctl !== 3'b111 || pops !== 4'b0010) begin bad++; $display("FAIL ord_np_ctl got=%b/%b exp=111/0010", ctl, pops); end
    total++; if (tlp_data_o !== {128'b0, hn}) begin bad++; $display("FAIL ord_np_data got=%h exp=%h", tlp_data_o, {128'b0, hn}); end
    tick();
    ph_m = 2; pd_m = 6; nph_m = 1;
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL ord_idle got=%b exp=000", ctl); end
    total++; if (dut.u_nph_cnt.cons_q !== 8'(nph_m)) begin bad++; $display("FAIL ord_nph_cons got=%0d exp=%0d", dut.u_nph_cnt.cons_q, nph_m); end
  endtask

  task automatic test_credit_block();
    logic [127:0] hp, hn;
    hp = mk_hdr(FMT_4DW_DATA, 10'd16, 32'h4000_0000);
    hn = mk_hdr(FMT_4DW_NODATA, 10'd1, 32'h5000_0000);
    fc_pd_limit_i = 12'(pd_m + 2);
    push_np(hn);
    push_p(hp, 2, 32'h30);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ctl !== 3'b000 || pops !== 4'b0000) begin bad++; $display("FAIL blk_cycle%0d got=%b/%b exp=000/0000", i, ctl, pops); end
    end
    fc_pd_limit_i = 12'(pd_m + 4);
    tick();
    total++; if (ctl !== 3'b110 || tlp_data_o !== {128'b0, hp}) begin bad++; $display("FAIL blk_p_hdr got=%b/%h exp=110/%h", ctl, tlp_data_o[127:0], hp); end
    tick();
    total++; if (ctl !== 3'b100 || tlp_data_o !== dword(32'h30, 0)) begin bad++; $display("FAIL blk_d0 got=%b/%h", ctl, tlp_data_o); end
    tick();
    total++; if (ctl !== 3'b101 || pops !== 4'b0101) begin bad++; $display("FAIL blk_d1 got=%b/%b exp=101/0101", ctl, pops); end
    tick();
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL blk_bubble got=%b exp=000", ctl); end
    tick();
    total++; if (ctl !== 3'b111 || tlp_data_o !== {128'b0, hn}) begin bad++; $display("FAIL blk_np got=%b/%h exp=111/%h", ctl, tlp_data_o[127:0], hn); end
    tick();
    ph_m = 3; pd_m = 10; nph_m = 2;
    total++; if (dut.u_pd_cnt.cons_q !== 12'(pd_m)) begin bad++; $display("FAIL blk_pd_cons got=%0d exp=%0d", dut.u_pd_cnt.cons_q, pd_m); end
  endtask

  task automatic test_half_range();
    fc_pd_limit_i = 12'(pd_m + 64);
    fc_ph_limit_i = 8'(ph_m + 129);
    push_p(mk_hdr(FMT_4DW_DATA, 10'd4, 32'h6000_0000), 1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ctl !== 3'b000) begin bad++; $display("FAIL half_blk%0d got=%b exp=000", i, ctl); end
    end
    fc_ph_limit_i = 8'(ph_m + 128);
    tick();
    total++; if (ctl !== 3'b110) begin bad++; $display("FAIL half_hdr got=%b exp=110", ctl); end
    tick();
    total++; if (ctl !== 3'b101 || tlp_data_o !== dword(32'h40, 0)) begin bad++; $display("FAIL half_d0 got=%b/%h", ctl, tlp_data_o); end
    tick();
    ph_m = 4; pd_m = 11;
    fc_ph_limit_i = 8'(ph_m + 8);
  endtask

  task automatic test_ready_stall();
    push_p(mk_hdr(FMT_4DW_DATA, 10'd24, 32'h7000_0000), 3, 32'h50);
    tick();
    total++; if (ctl !== 3'b110) begin bad++; $display("FAIL stall_hdr got=%b exp=110", ctl); end
    tick();
    total++; if (ctl !== 3'b100 || pops !== 4'b0100) begin bad++; $display("FAIL stall_d0 got=%b/%b exp=100/0100", ctl, pops); end
    tick();
    total++; if (tlp_data_o !== dword(32'h50, 1)) begin bad++; $display("FAIL stall_d1 got=%h exp=%h", tlp_data_o, dword(32'h50, 1)); end
    tlp_ready_i = 1'b0;
    #1;
    total++; if (pops !== 4'b0000) begin bad++; $display("FAIL stall_nopop got=%b exp=0000", pops); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ctl !== 3'b100 || tlp_data_o !== dword(32'h50, 1) || pops !== 4'b0000) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%b/%h", i, ctl, pops, tlp_data_o);
      end
    end
    tlp_ready_i = 1'b1;
    #1;
    total++; if (pops !== 4'b0100) begin bad++; $display("FAIL stall_release got=%b exp=0100", pops); end
    tick();
    total++; if (ctl !== 3'b101 || tlp_data_o !== dword(32'h50, 2) || pops !== 4'b0101) begin bad++; $display("FAIL stall_d2 got=%b/%b", ctl, pops); end
    tick();
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL stall_idle got=%b exp=000", ctl); end
    ph_m = 5; pd_m = 17;
  endtask

  task automatic test_nph_wrap();
    int errs;
    errs = 0;
    while (nph_m != 0) begin
      fc_nph_limit_i = 8'(nph_m + 1);
      push_np(mk_hdr(FMT_4DW_NODATA, 10'd1, 32'(nph_m)));
      tick();
      total++;
      if ({ctl, pops} !== 7'b111_0010) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL wrap_np cons=%0d got=%b exp=1110010", nph_m, {ctl, pops});
      end
      tick();
      nph_m = (nph_m + 1) % 256;
      if (errs > 20) break;
    end
    total++; if (dut.u_nph_cnt.cons_q !== 8'd0) begin bad++; $display("FAIL wrap_cons got=%0d exp=0", dut.u_nph_cnt.cons_q); end
    fc_nph_limit_i = 8'd0;
    push_np(mk_hdr(FMT_4DW_NODATA, 10'd1, 32'hABCD_0000));
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ctl !== 3'b000) begin bad++; $display("FAIL wrap_zero_avail%0d got=%b exp=000", i, ctl); end
    end
    fc_nph_limit_i = 8'd1;
    tick();
    total++; if (ctl !== 3'b111) begin bad++; $display("FAIL wrap_after got=%b exp=111", ctl); end
    tick();
    nph_m = 1;
  endtask

  task automatic test_reset_mid();
    push_p(mk_hdr(FMT_4DW_DATA, 10'd24, 32'h8000_0000), 3, 32'h60);
    tick();
    tick();
    total++; if (dut.state_q !== P_DATA) begin bad++; $display("FAIL rmid_pre got=%0d exp=%0d", dut.state_q, P_DATA); end
    rst_n = 1'b0;
    tick();
    total++; if (dut.state_q !== IDLE || ctl !== 3'b000) begin bad++; $display("FAIL rmid_state got=%0d/%b exp=%0d/000", dut.state_q, ctl, IDLE); end
    total++;
    if ({dut.u_ph_cnt.cons_q, dut.u_pd_cnt.cons_q, dut.u_nph_cnt.cons_q} !== 28'b0) begin
      bad++; $display("FAIL rmid_cons got=%h exp=0",
                      {dut.u_ph_cnt.cons_q, dut.u_pd_cnt.cons_q, dut.u_nph_cnt.cons_q});
    end
    rst_n = 1'b1;
    ph_m = 0; pd_m = 0; nph_m = 0;
    tick();
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL rmid_after got=%b exp=000", ctl); end
  endtask

  initial begin
    test_reset();
    test_single_p();
    test_p_before_np();
    test_credit_block();
    test_half_range();
    test_ready_stall();
    test_nph_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_tx_arbiter.md
Name: tl_tx_arbiter

Overview:
- Transaction-layer Tx egress stage, directly downstream of the AXI slave packer.
- Drains the P header, P data and NP header FIFOs into one 256-bit TLP stream toward the data link layer.
- Gates each TLP on PCIe flow-control credits (PH, PD, NPH) and enforces the ordering rule that NP never passes P.
- Returns `p_sent` to the packer's payload counter.

Parameters:
- TX_DEPTH_LG2, 3, width of the posted-payload count input (matches the Tx FIFO depth).
- PH_W, 8, posted-header credit counter width (modulo 2^PH_W).
- PD_W, 12, posted-data credit counter width, in 16 B units.
- NPH_W, 8, non-posted-header credit counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- p_hdr_empty_i  in  1  P header FIFO empty
- p_hdr_rdata_i  in  128  P header FIFO head (show-ahead, tlp_memory_req_hdr_t)
- p_hdr_rden_o  out  1  P header pop
- p_data_empty_i  in  1  P data FIFO empty
- p_data_rdata_i  in  256  P data FIFO head (show-ahead)
- p_data_rden_o  out  1  P data pop
- p_payload_cnt_i  in  TX_DEPTH_LG2  number of complete write payloads buffered
- p_sent_o  out  1  one-cycle pulse when a posted TLP is fully sent
- np_hdr_empty_i  in  1  NP header FIFO empty
- np_hdr_rdata_i  in  128  NP header FIFO head
- np_hdr_rden_o  out  1  NP header pop
- fc_ph_limit_i  in  PH_W  PH credit limit from the DLL
- fc_pd_limit_i  in  PD_W  PD credit limit from the DLL
- fc_nph_limit_i  in  NPH_W  NPH credit limit from the DLL
- tlp_valid_o  out  1  TLP beat valid
- tlp_data_o  out  256  TLP beat data
- tlp_sop_o  out  1  first beat of TLP
- tlp_eop_o  out  1  last beat of TLP
- tlp_ready_i  in  1  DLL accepts beat

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset state:
  - state = IDLE.
  - All consumed counters (ph_cons, pd_cons, nph_cons) = 0.
  - beat counter = 0.
  - All outputs 0.
- Length decode: len_dw = {length_h, length_l}; 0 means 1024.
  - PD credits needed = ceil(len_dw/4).
  - Data beats = ceil(len_dw/8).
- Credit check (per type, width N): avail = (limit - consumed) mod 2^N.
  - Eligible when need <= avail <= 2^(N-1).
  - An avail of 0, or one above the half-range, blocks.
- P eligible: !p_hdr_empty_i & p_payload_cnt_i != 0 & PH need 1 & PD need per the length decode.
- NP eligible: !np_hdr_empty_i & p_hdr_empty_i & NPH need 1.
  - NP never issues while any P header is pending, even if that P is credit-blocked.
- FSM states: IDLE, P_HDR, P_DATA, NP_HDR.
  - IDLE: if P eligible -> P_HDR; else if NP eligible -> NP_HDR. Outputs idle in this cycle.
  - P_HDR: tlp_valid_o=1, tlp_sop_o=1, tlp_data_o={128'b0, p_hdr_rdata_i}.
    - On handshake: p_hdr_rden_o=1; ph_cons+=1; pd_cons+=PD need; load beat counter = beats-1; -> P_DATA.
  - P_DATA: tlp_valid_o = !p_data_empty_i; tlp_data_o = p_data_rdata_i; tlp_eop_o = (beat counter==0).
    - Handshake pops p_data and decrements the counter.
    - Handshake on the eop beat: p_sent_o pulse; -> IDLE.
  - NP_HDR: tlp_valid_o=1, sop=eop=1, data={128'b0, np_hdr_rdata_i}.
    - On handshake: np_hdr_rden_o=1; nph_cons+=1; -> IDLE.
- Latency: 1 cycle from eligibility to header beat. One idle bubble between consecutive TLPs.
- Handshake = tlp_valid_o & tlp_ready_i.
  - While ready is low, data, sop and eop hold stable; no pops occur.
  - valid never drops once asserted except when the data FIFO runs empty in P_DATA.
- Pops are combinational with the handshake (rden = valid & ready & state).
- Consumed counters wrap modulo 2^N with no saturation.
- Limit inputs may change in any cycle; they are sampled only in IDLE.
- Reset mid-TLP abandons the packet. Upstream FIFOs share rst_n.

Decomposition:
- PCIE_PKG additions:
  - FMT_4DW_NODATA = 3'b001, FMT_4DW_DATA = 3'b011.
  - FC credit width localparams.
  - tx_arb_state_t enum.
- Sub-module tl_fc_credit_cnt (parameter N): holds the consumed counter, computes avail and the eligible flag, consume-by-amount input. Instantiate 3 times.

Test Plan:
- PH/PD/NPH limits 8/64/8. One P header with len=16 DW, 2 data beats, payload_cnt=1 -> header beat with sop, 2 data beats (eop on the 2nd), p_sent 1 pulse, ph_cons=1, pd_cons=4.
- P and NP both queued -> P TLP completes first. NP header issues only after p_hdr_empty_i rises, with sop=eop=1, nph_cons=1.
- PD limit 2, P len=16 DW (needs 4), NP queued -> nothing issues. Raise PD limit to 4 -> P issues, then NP.
- tlp_ready_i low 3 cycles mid-P_DATA -> beat held stable, no pops. Released -> remaining beats in order.
- Preset consumed counters via 255 NP TLPs (NPH limit 0 + wrap) -> nph_cons wraps to 0 and eligibility stays correct across the wrap.
- Assert rst_n low during P_DATA -> next cycle state IDLE, tlp_valid_o=0, counters 0.
